shift_rows_stream: RTL and testbench

- Parametrised, handshaked ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
- Supports state widths Nb = 4, 6 or 8 columns, and selects forward or inverse direction per transaction.
- Registers each result into a 2-entry output buffer, so the round pipeline can stall without losing data.
- Sits between SubBytes and MixColumns in the encrypt path, and between InvShiftRows users in the decrypt path.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/shift_rows_core.sv | 23 ++
 rtl/shift_rows_stream.sv | 75 +++++++
 tb/tb_shift_rows_stream.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath helpers: legal state sizes, state width, ShiftRows row
// offsets and the column-major byte index used by every stage.
package aes_pkg;

    function automatic bit nb_legal(input int nb);
        return (nb == 32'd4) || (nb == 32'd6) || (nb == 32'd8);
    endfunction

    function automatic int state_width(input int nb);
        return 32'd32 * nb;
    endfunction

    // Rijndael widens the offsets of rows 2 and 3 only for the 256-bit block.
    function automatic int shift_offset(input int nb, input int row);
        int off;
        case (row)
            32'd0:   off = 32'd0;
            32'd1:   off = 32'd1;
            32'd2:   off = (nb == 32'd8) ? 32'd3 : 32'd2;
            32'd3:   off = (nb == 32'd8) ? 32'd4 : 32'd3;
            default: off = 32'd0;
        endcase
        return off;
    endfunction

    function automatic int idx(input int r, input int c);
        return 32'd4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_core
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic                       inv,
    input  logic [state_width(NB)-1:0] state,
    output logic [state_width(NB)-1:0] result
);

    // Each output byte picks one of two fixed source bytes, so the permutation is pure wiring plus a 2:1 mux.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF   = shift_offset(NB, r);
            localparam int SRC_F = (c + OFF) % NB;
            localparam int SRC_I = (c + NB - OFF) % NB;
            assign result[8*idx(r, c) +: 8] = inv ? state[8*idx(r, SRC_I) +: 8]
                                                  : state[8*idx(r, SRC_F) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Handshaked ShiftRows stage: permutes the accepted state and queues it, with its
// mode bit, in a 2-entry FIFO so the round pipeline can stall without loss.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB = 4,
    parameter int W  = state_width(NB)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_inv,
    output logic [1:0]   occupancy
);

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    logic [W-1:0] shifted_s;
    logic [W-1:0] data_r [2];
    logic [1:0]   inv_r;
    logic         head_r;
    logic         tail_r;
    logic [1:0]   count_r;
    logic         push_s;
    logic         pop_s;

    shift_rows_core #(.NB(NB)) u_core (
        .inv    (in_inv),
        .state  (in_data),
        .result (shifted_s)
    );

    assign in_ready  = rst_n && (count_r < 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = data_r[head_r];
    assign out_inv   = inv_r[head_r];
    assign occupancy = count_r;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // FIFO storage, pointers and count; reset also wipes the entries so out_data reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r[0] <= '0;
            data_r[1] <= '0;
            inv_r     <= 2'b00;
            head_r    <= 1'b0;
            tail_r    <= 1'b0;
            count_r   <= 2'd0;
        end else begin
            if (push_s) begin
                data_r[tail_r] <= shifted_s;
                inv_r[tail_r]  <= in_inv;
                tail_r         <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench: directed and random blocks on NB=4 and NB=8 instances,
// checked against a row/column reference model and a queue-based FIFO model.
module tb_shift_rows_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_inv;
    logic [127:0] in_data;
    logic         out_valid, out_ready, out_inv;
    logic [127:0] out_data;
    logic [1:0]   occupancy;

    logic         v8, rdy8, inv8, ov8, ordy8, oi8;
    logic [255:0] d8, od8;
    logic [1:0]   occ8;

    int checks = 0;
    int errors = 0;
    logic [128:0] q[$];
    logic [127:0] blk [3];
    logic [127:0] tmp;
    logic [255:0] e8;

    always #5 clk = ~clk;

    shift_rows_stream #(.NB(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
        .occupancy(occupancy)
    );

    shift_rows_stream #(.NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .in_inv(inv8), .in_data(d8), .out_valid(ov8),
        .out_ready(ordy8), .out_data(od8), .out_inv(oi8),
        .occupancy(occ8)
    );

    // Reference: out[r][c] = in[r][(c +/- s_r) mod nb], byte k at row k%4, column k/4.
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] din, input logic inv);
        int s [4];
        int src;
        logic [255:0] res;
        res = '0;
        if (nb == 8) s = '{0, 1, 3, 4};
        else         s = '{0, 1, 2, 3};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - s[r] + nb) % nb : (c + s[r]) % nb;
                res[8*(4*c+r) +: 8] = din[8*(4*src+r) +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] ref4(input logic [127:0] din, input logic inv);
        logic [255:0] w;
        w = ref_shift(4, {128'd0, din}, inv);
        return w[127:0];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock on the NB=4 instance with the FIFO model advanced and all outputs compared.
    task automatic tick4(input string tag);
        logic rst_at_edge, push, pop;
        logic [128:0] ent;
        rst_at_edge = rst_n;
        push = in_valid && rst_n && (q.size() < 2);
        pop  = out_ready && (q.size() != 0);
        ent  = {in_inv, ref4(in_data, in_inv)};
        @(posedge clk);
        #1;
        if (!rst_at_edge) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(ent);
        end
        chk({tag, ".valid"}, 256'(out_valid), 256'(q.size() != 0));
        chk({tag, ".occ"}, 256'(occupancy), 256'(q.size()));
        chk({tag, ".in_ready"}, 256'(in_ready), 256'(rst_n && (q.size() < 2)));
        if (q.size() != 0) begin
            chk({tag, ".data"}, 256'(out_data), 256'(q[0][127:0]));
            chk({tag, ".inv"}, 256'(out_inv), 256'(q[0][128]));
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        v8 = 1'b0; inv8 = 1'b0; d8 = '0; ordy8 = 1'b1;

        // Reset state
        tick4("rst0");
        tick4("rst1");
        chk("rst.out_data", 256'(out_data), 256'd0);
        chk("rst.out_inv", 256'(out_inv), 256'd0);
        chk("rst.ov8", 256'(ov8), 256'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready_after", 256'(in_ready), 256'd1);

        // Known-answer vectors, NB=4, forward then inverse then round-trip
        in_valid = 1'b1; in_inv = 1'b0;
        in_data  = 128'h0f0e0d0c0b0a09080706050403020100;
        tick4("kat_fwd");
        chk("kat_fwd.const", 256'(out_data), 256'(128'h0b06010c07020d08030e09040f0a0500));
        chk("kat_fwd.inv", 256'(out_inv), 256'd0);
        in_inv = 1'b1;
        tick4("kat_inv");
        chk("kat_inv.const", 256'(out_data), 256'(128'h0306090c0f0205080b0e0104070a0d00));
        chk("kat_inv.inv", 256'(out_inv), 256'd1);
        in_inv = 1'b0;
        in_data = 128'h0306090c0f0205080b0e0104070a0d00;
        tick4("roundtrip");
        chk("roundtrip.const", 256'(out_data), 256'(128'h0f0e0d0c0b0a09080706050403020100));
        in_valid = 1'b0;
        tick4("drain");

        // NB=8 forward with byte k = k, then a random inverse block
        for (int k = 0; k < 32; k++) d8[8*k +: 8] = 8'(k);
        v8 = 1'b1; inv8 = 1'b0;
        e8 = ref_shift(8, d8, 1'b0);
        @(posedge clk); #1;
        chk("nb8.valid", 256'(ov8), 256'd1);
        chk("nb8.bytes0_3", 256'(od8[31:0]), 256'(32'h130e0500));
        chk("nb8.row0", 256'({od8[224 +: 8], od8[96 +: 8], od8[32 +: 8]}), 256'(24'h1c0c04));
        chk("nb8.model", od8, e8);
        d8 = {rnd128(), rnd128()}; inv8 = 1'b1;
        e8 = ref_shift(8, d8, 1'b1);
        @(posedge clk); #1;
        chk("nb8inv.model", od8, e8);
        chk("nb8inv.inv", 256'(oi8), 256'd1);
        v8 = 1'b0;
        @(posedge clk); #1;
        chk("nb8.drained", 256'(ov8), 256'd0);

        // Back-pressure: three alternating-mode blocks against a stalled output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) blk[i] = rnd128();
        in_valid = 1'b1;
        in_data = blk[0]; in_inv = 1'b0; tick4("bp0");
        in_data = blk[1]; in_inv = 1'b1; tick4("bp1");
        in_data = blk[2]; in_inv = 1'b0; tick4("bp2");
        tick4("bp3");
        chk("bp.full_occ", 256'(occupancy), 256'd2);
        chk("bp.held", 256'(out_data), 256'(ref4(blk[0], 1'b0)));
        out_ready = 1'b1;
        tick4("bp_rel0");
        chk("bp.order1", 256'(out_data), 256'(ref4(blk[1], 1'b1)));
        tick4("bp_rel1");
        chk("bp.order2", 256'(out_data), 256'(ref4(blk[2], 1'b0)));
        in_valid = 1'b0;
        tick4("bp_rel2");

        // Streaming: 16 back-to-back random blocks with out_ready high
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = rnd128();
            in_inv  = 1'($urandom_range(0, 1));
            tmp     = ref4(in_data, in_inv);
            tick4("stream");
            chk("stream.every_cycle", 256'(out_valid), 256'd1);
            chk("stream.direct", 256'(out_data), 256'(tmp));
            chk("stream.occ_le1", 256'(occupancy <= 2'd1), 256'd1);
        end
        in_valid = 1'b0;
        tick4("stream_end");

        // Reset mid-stream with the buffer full
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = rnd128(); in_inv = 1'b1; tick4("mr0");
        in_data = rnd128(); in_inv = 1'b0; tick4("mr1");
        chk("mr.full", 256'(occupancy), 256'd2);
        rst_n = 1'b0;
        #1;
        chk("mr.in_ready_in_reset", 256'(in_ready), 256'd0);
        in_data = rnd128();
        tick4("mr_rst");
        chk("mr.out_data_zero", 256'(out_data), 256'd0);
        rst_n = 1'b1;
        #1;
        chk("mr.in_ready_after", 256'(in_ready), 256'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick4("mr_after");
        chk("mr.no_stale", 256'(out_valid), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
